// File: rtl/clk_rst_sequencer.sv
// clk_rst_sequencer: 48 MHz power-of-two clock enables plus POR, debounced-button and soft-reset sequencing
module clk_rst_sequencer #(
  parameter int N_ENA = 3,
  parameter int POR_CYCLES = 256,
  parameter int DEB_CYCLES = 4096,
  parameter int RST_MIN = 64,
  parameter int ENA_GATE = 0
) (
  input  logic             clk_48M,
  input  logic             nRESET,
  input  logic             btn_n,
  input  logic             soft_rst,
  output logic [N_ENA-1:0] ena,
  output logic [N_ENA-1:0] clk_div,
  output logic             core_rst,
  output logic             rst_done,
  output logic [1:0]       state
);
  localparam int PW = $clog2(POR_CYCLES);
  localparam int MW = RST_MIN > 1 ? $clog2(RST_MIN) : 1;
  localparam int SW = PW > MW ? PW : MW;
  localparam int DW = $clog2(DEB_CYCLES);
  localparam logic [SW-1:0] POR_LAST = SW'(POR_CYCLES - 1);
  localparam logic [SW-1:0] MIN_LAST = SW'(RST_MIN - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  typedef enum logic [1:0] {POR, HOLD, STRETCH, RUN} state_t;
  state_t st;
  logic [N_ENA-1:0] cnt;
  logic [1:0] sync;
  logic deb;
  logic [DW-1:0] deb_cnt;
  logic [SW-1:0] seq;
  logic req;
  assign clk_div = cnt;
  assign state = st;
  assign req = !deb || soft_rst;
  for (genvar i = 0; i < N_ENA; i++) begin : g_ena
    assign ena[i] = (&cnt[i:0]) && !(ENA_GATE != 0 && core_rst);
  end
  always_ff @(posedge clk_48M or negedge nRESET)
    if (!nRESET) cnt <= '0;
    else cnt <= cnt + N_ENA'(1);
  // the debounced level only follows the synced button after DEB_CYCLES consecutive disagreeing cycles
  always_ff @(posedge clk_48M or negedge nRESET)
    if (!nRESET) begin
      sync <= 2'b11;
      deb <= 1'b1;
      deb_cnt <= '0;
    end else begin
      sync <= {sync[0], btn_n};
      if (sync[1] == deb) deb_cnt <= '0;
      else if (deb_cnt == DEB_LAST) begin
        deb <= sync[1];
        deb_cnt <= '0;
      end else deb_cnt <= deb_cnt + DW'(1);
    end
  always_ff @(posedge clk_48M or negedge nRESET)
    if (!nRESET) begin
      st <= POR;
      seq <= '0;
      core_rst <= 1'b1;
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b0;
      case (st)
        POR:
          if (seq == POR_LAST) begin
            seq <= '0;
            st <= req ? HOLD : RUN;
            core_rst <= req;
            rst_done <= !req;
          end else seq <= seq + SW'(1);
        HOLD:
          if (!req) begin
            st <= STRETCH;
            seq <= '0;
          end
        STRETCH:
          if (req) st <= HOLD;
          else if (seq == MIN_LAST) begin
            st <= RUN;
            core_rst <= 1'b0;
            rst_done <= 1'b1;
          end else seq <= seq + SW'(1);
        RUN:
          if (req) begin
            st <= HOLD;
            core_rst <= 1'b1;
          end
      endcase
    end
endmodule

// File: tb/tb_clk_rst_sequencer.sv
// tb_clk_rst_sequencer: directed scenarios plus randomized run against a phase/timer reference model
module tb_clk_rst_sequencer;
  localparam int N = 3, POR = 8, DEB = 16, RMIN = 4;
  logic clk_48M = 0, nRESET = 0, btn_n = 1, soft_rst = 0;
  logic [N-1:0] ena, ena_g, clk_div, clk_div_g;
  logic core_rst, core_rst_g, rst_done, rst_done_g;
  logic [1:0] state, state_g;
  int n_chk = 0, n_fail = 0;
  always #5 clk_48M = ~clk_48M;
  clk_rst_sequencer #(.N_ENA(N), .POR_CYCLES(POR), .DEB_CYCLES(DEB), .RST_MIN(RMIN), .ENA_GATE(0)) dut (
    .clk_48M(clk_48M), .nRESET(nRESET), .btn_n(btn_n), .soft_rst(soft_rst), .ena(ena),
    .clk_div(clk_div), .core_rst(core_rst), .rst_done(rst_done), .state(state));
  clk_rst_sequencer #(.N_ENA(N), .POR_CYCLES(POR), .DEB_CYCLES(DEB), .RST_MIN(RMIN), .ENA_GATE(1)) dut_g (
    .clk_48M(clk_48M), .nRESET(nRESET), .btn_n(btn_n), .soft_rst(soft_rst), .ena(ena_g),
    .clk_div(clk_div_g), .core_rst(core_rst_g), .rst_done(rst_done_g), .state(state_g));
  // reference model: edges since release, phase (0 POR,1 HOLD,2 STRETCH,3 RUN) with elapsed-edge timer
  int m_cyc, m_st, m_tmr, m_diff;
  logic m_deb, m_core, m_done, m_syn, m_req;
  logic hist[$];
  logic [N-1:0] exp_ena, exp_div;
  always @(posedge clk_48M or negedge nRESET)
    if (!nRESET) begin
      m_cyc = 0; m_st = 0; m_tmr = 0; m_diff = 0;
      m_deb = 1; m_core = 1; m_done = 0;
      hist.delete();
    end else begin
      m_syn = hist.size() >= 2 ? hist[hist.size()-2] : 1'b1;
      m_req = !m_deb || soft_rst;
      hist.push_back(btn_n);
      if (hist.size() > 3) void'(hist.pop_front());
      m_diff = (m_syn != m_deb) ? m_diff + 1 : 0;
      if (m_diff == DEB) begin m_deb = m_syn; m_diff = 0; end
      m_cyc++;
      m_done = 0;
      case (m_st)
        0: begin m_tmr++; if (m_tmr == POR) begin m_tmr = 0; m_st = m_req ? 1 : 3; m_done = !m_req; end end
        1: if (!m_req) begin m_st = 2; m_tmr = 0; end
        2: if (m_req) m_st = 1; else begin m_tmr++; if (m_tmr == RMIN) begin m_st = 3; m_done = 1; end end
        default: if (m_req) m_st = 1;
      endcase
      m_core = m_st != 3;
    end
  always_comb begin
    for (int i = 0; i < N; i++) exp_ena[i] = (m_cyc % (2 << i)) == ((2 << i) - 1);
    exp_div = N'(m_cyc % (1 << N));
  end
  task automatic tick;
    @(posedge clk_48M);
    @(negedge clk_48M);
  endtask
  task automatic test_reset;
    nRESET = 0; btn_n = 1; soft_rst = 0;
    repeat (3) tick();
    n_chk++;
    if (state !== 2'd0 || core_rst !== 1'b1 || rst_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: state=%0d core_rst=%b rst_done=%b, want 0 1 0", state, core_rst, rst_done);
    end
    n_chk++;
    if (clk_div !== '0 || ena !== '0 || ena_g !== '0) begin
      n_fail++; $display("FAIL reset_div: clk_div=%b ena=%b ena_g=%b, want 0", clk_div, ena, ena_g);
    end
  endtask
  task automatic test_por;
    int edges = 0;
    nRESET = 1;
    while (core_rst === 1'b1 && edges < 50) begin
      tick(); edges++;
      n_chk++;
      if (state !== 2'(m_st)) begin n_fail++; $display("FAIL por_state: state=%0d model=%0d", state, m_st); end
    end
    n_chk++;
    if (edges != POR) begin n_fail++; $display("FAIL por_len: core_rst fell after %0d edges, want %0d", edges, POR); end
    n_chk++;
    if (rst_done !== 1'b1 || state !== 2'd3) begin
      n_fail++; $display("FAIL por_done: rst_done=%b state=%0d, want 1 3", rst_done, state);
    end
    tick();
    n_chk++;
    if (rst_done !== 1'b0) begin n_fail++; $display("FAIL por_done_pulse: rst_done=%b, want 0", rst_done); end
  endtask
  task automatic test_enables;
    int c0 = 0, c1 = 0, c2 = 0, hi2 = 0;
    repeat (32) begin
      tick();
      n_chk++;
      if (clk_div !== exp_div || ena !== exp_ena || ena_g !== exp_ena) begin
        n_fail++; $display("FAIL ena_model: clk_div=%b ena=%b ena_g=%b, want %b %b %b", clk_div, ena, ena_g, exp_div, exp_ena, exp_ena);
      end
      if (ena[2]) begin
        n_chk++;
        if (clk_div !== 3'd7) begin n_fail++; $display("FAIL ena2_at7: clk_div=%0d at ena[2], want 7", clk_div); end
      end
      c0 += int'(ena[0]); c1 += int'(ena[1]); c2 += int'(ena[2]); hi2 += int'(clk_div[2]);
    end
    n_chk++;
    if (c0 != 16 || c1 != 8 || c2 != 4 || hi2 != 16) begin
      n_fail++; $display("FAIL ena_counts: %0d %0d %0d div2hi=%0d, want 16 8 4 16", c0, c1, c2, hi2);
    end
  endtask
  task automatic test_debounce;
    int edges = 0, seen_hi = 0;
    btn_n = 0;
    repeat (10) tick();
    btn_n = 1;
    repeat (40) begin tick(); seen_hi += int'(core_rst); end
    n_chk++;
    if (seen_hi != 0) begin n_fail++; $display("FAIL deb_glitch: core_rst high %0d cycles, want 0", seen_hi); end
    btn_n = 0;
    while (core_rst !== 1'b1 && edges < 60) begin tick(); edges++; end
    n_chk++;
    if (edges != 2 + DEB + 1) begin n_fail++; $display("FAIL deb_delay: core_rst rose after %0d edges, want %0d", edges, 2 + DEB + 1); end
    repeat (40 - edges) tick();
    n_chk++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL deb_hold: state=%0d, want 1", state); end
    btn_n = 1; edges = 0;
    while (state !== 2'd3 && edges < 100) begin tick(); edges++; end
    n_chk++;
    if (edges != 2 + DEB + 1 + RMIN || rst_done !== 1'b1) begin
      n_fail++; $display("FAIL deb_release: RUN after %0d edges rst_done=%b, want %0d 1", edges, rst_done, 2 + DEB + 1 + RMIN);
    end
  endtask
  task automatic test_stretch;
    int n = 0;
    soft_rst = 1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 5) soft_rst = 0;
      n_chk++;
      if (state !== (k <= 5 ? 2'd1 : k <= 9 ? 2'd2 : 2'd3) || rst_done !== (k == 10) || core_rst !== (k < 10)) begin
        n_fail++; $display("FAIL stretch_seq k=%0d: state=%0d rst_done=%b core_rst=%b", k, state, rst_done, core_rst);
      end
    end
    soft_rst = 1;
    repeat (3) tick();
    soft_rst = 0;
    repeat (2) tick();
    soft_rst = 1;
    tick();
    soft_rst = 0;
    n_chk++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL stretch_reenter: state=%0d, want 1", state); end
    while (state !== 2'd3 && n < 30) begin tick(); n++; end
    n_chk++;
    if (n != RMIN + 1) begin n_fail++; $display("FAIL stretch_restart: RUN after %0d edges, want %0d", n, RMIN + 1); end
  endtask
  task automatic test_gating;
    int free = 0;
    logic [N-1:0] prev;
    nRESET = 0;
    tick();
    nRESET = 1;
    prev = clk_div_g;
    repeat (POR - 1) begin
      tick();
      n_chk++;
      if (core_rst_g !== 1'b1 || ena_g !== '0 || clk_div_g === prev || clk_div_g !== exp_div) begin
        n_fail++; $display("FAIL gate_por: core_rst=%b ena_g=%b clk_div_g=%b, want 1 0 %b", core_rst_g, ena_g, clk_div_g, exp_div);
      end
      prev = clk_div_g;
      free += int'(|ena && core_rst);
    end
    n_chk++;
    if (free == 0) begin n_fail++; $display("FAIL gate_free: ungated ena idle in reset, got %0d pulses want >0", free); end
    tick();
  endtask
  task automatic test_mid_reset;
    int edges = 0;
    repeat (5) tick();
    nRESET = 0;
    #1;
    n_chk++;
    if (state !== 2'd0 || core_rst !== 1'b1 || clk_div !== '0 || rst_done !== 1'b0) begin
      n_fail++; $display("FAIL mid_async: state=%0d core_rst=%b clk_div=%b rst_done=%b", state, core_rst, clk_div, rst_done);
    end
    @(negedge clk_48M);
    nRESET = 1;
    while (core_rst === 1'b1 && edges < 50) begin tick(); edges++; end
    n_chk++;
    if (edges != POR) begin n_fail++; $display("FAIL mid_por: core_rst fell after %0d edges, want %0d", edges, POR); end
    btn_n = 0;
    repeat (30) tick();
    btn_n = 1;
    nRESET = 0;
    tick();
    nRESET = 1;
    edges = 0;
    while (state !== 2'd3 && edges < 50) begin tick(); edges++; end
    n_chk++;
    if (edges != POR) begin n_fail++; $display("FAIL mid_deb_released: RUN after %0d edges, want %0d", edges, POR); end
  endtask
  task automatic test_random;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 24) == 0) btn_n = !btn_n;
      soft_rst = $urandom_range(0, 19) == 0;
      nRESET = !nRESET ? 1'b1 : ($urandom_range(0, 299) != 0);
      tick();
      n_chk++;
      if (state !== 2'(m_st) || core_rst !== m_core || rst_done !== m_done || clk_div !== exp_div ||
          ena !== exp_ena || ena_g !== (exp_ena & {N{!m_core}})) begin
        n_fail++;
        $display("FAIL random k=%0d: st=%0d core=%b done=%b div=%b ena=%b ena_g=%b, want %0d %b %b %b %b %b",
                 k, state, core_rst, rst_done, clk_div, ena, ena_g, m_st, m_core, m_done, exp_div, exp_ena, exp_ena & {N{!m_core}});
      end
    end
  endtask
  initial begin
    test_reset();
    test_por();
    test_enables();
    test_debounce();
    test_stretch();
    test_gating();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_rst_sequencer.md
Name: clk_rst_sequencer

Overview:
- Parametrised clock-enable and reset sequencer for arcade cores running from the 48 MHz PLL clock.
- Replaces the ad-hoc divider and power-on delay counter in board top levels with one block.
- Generates N power-of-two clock enables and divided square waves.
- Holds core reset for a configurable power-on time.
- Adds a synchronised, debounced reset button, a soft-reset request and a minimum reset-stretch time.

Parameters:
N_ENA, 3, number of divider stages; stage i divides by 2^(i+1)
POR_CYCLES, 256, core reset hold after nRESET release, in clk_48M cycles (>=2)
DEB_CYCLES, 4096, cycles the synchronised button must be stable before its debounced level changes (>=2)
RST_MIN, 64, minimum core reset length after a button/soft reset is released (>=1)
ENA_GATE, 0, 1 = force ena to 0 while core_rst is high; 0 = enables free-run

Ports:
clk_48M  in  1  system clock
nRESET  in  1  asynchronous active-low reset (PLL lock)
btn_n  in  1  asynchronous reset button, active low
soft_rst  in  1  synchronous reset request, active high, level
ena  out  N_ENA  one-cycle clock-enable pulses, bit i every 2^(i+1) cycles
clk_div  out  N_ENA  divided clocks, bit i = counter bit i (50% duty)
core_rst  out  1  active-high reset to the game core
rst_done  out  1  one-cycle pulse on entry to RUN
state  out  2  0=POR 1=HOLD 2=STRETCH 3=RUN

Behaviour:
- Reset (nRESET=0, asynchronous) sets:
  - divider counter cnt (N_ENA bits) = 0, so ena = 0 and clk_div = 0.
  - core_rst = 1, rst_done = 0, state = POR.
  - Both synchroniser flops = 1; debounced button = 1 (released).
  - Debounce counter = 0; sequence counter = 0.
- Divider:
  - cnt increments every cycle, wraps from all-ones to 0.
  - clk_div = cnt.
  - ena[i] = 1 exactly in cycles where cnt[i:0] is all ones. This is combinational from the cnt register.
  - Divider runs through POR/HOLD/STRETCH; only nRESET clears it.
  - If ENA_GATE=1, ena is ANDed with ~core_rst.
- Button path:
  - Two-flop synchroniser, then debounce counter.
  - Counter clears whenever the synced value equals the debounced value.
  - Otherwise the counter increments. When it reaches DEB_CYCLES-1, the debounced value takes the synced value and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles never changes the debounced level.
  - Request req = (debounced button == 0) | soft_rst.
- FSM, with seq = sequence counter:
  - POR: seq counts up each edge. At the edge where seq == POR_CYCLES-1, go to HOLD if req else RUN, and clear seq. core_rst therefore drops exactly POR_CYCLES edges after nRESET release when req=0. req does not extend POR itself.
  - RUN: core_rst=0. req=1 → HOLD on the next edge, with core_rst=1 from that edge.
  - HOLD: core_rst=1. Stays while req=1. When req=0 → STRETCH, seq=0.
  - STRETCH: core_rst=1, seq counts. req=1 → HOLD (stretch restarts later). At seq == RST_MIN-1 with req=0 → RUN.
- rst_done: registered. High for the single cycle following every entry to RUN, coincident with the first core_rst=0 cycle.
- core_rst is registered, glitch-free, and asserted in every state except RUN.
- nRESET asserted mid-operation: immediate asynchronous return to reset values; the full POR sequence is repeated.
- Counter widths: clog2 of each limit. Compares are against limit-1 using exact equality; no off-by-one slack.

Test Plan:
- POR (POR_CYCLES=8): release nRESET, btn_n=1 → core_rst low after exactly 8 edges; rst_done one pulse on that cycle; state POR→RUN.
- Enables (N_ENA=3):
  - 32 cycles after reset → ena[0] every 2nd, ena[1] every 4th, ena[2] every 8th cycle.
  - First ena[2] when cnt=7; clk_div[2] 4 high / 4 low.
- Debounce (DEB_CYCLES=16) in RUN:
  - btn_n low 10 cycles → core_rst stays 0.
  - btn_n low 40 cycles → core_rst high 2+16+1 cycles after the fall.
- Stretch (RST_MIN=4):
  - soft_rst high 5 cycles in RUN → HOLD for 5 cycles, then STRETCH 4 cycles, then RUN with rst_done pulse.
  - soft_rst re-pulsed in STRETCH → back to HOLD, stretch count restarts.
- Gating: ENA_GATE=1 → ena all 0 whenever core_rst=1 while clk_div keeps toggling. ENA_GATE=0 → ena toggles during reset.
- Mid-run nRESET:
  - Pulse nRESET low 1 cycle in RUN → cnt=0, core_rst=1 asynchronously, state=POR.
  - Full POR_CYCLES delay repeats; debouncer returns to released.
